keypad_scan_entry: RTL

- Input-side counterpart of the multiplexed 7-segment display driver. The display drives digit cathodes in turn; this block drives the columns of a 4x4 matrix keypad in turn and reads the rows.
- Debounces the pressed key, encodes it as a 4-bit hex code, and shifts it into a 4-digit entry buffer. The buffer's HEX0..HEX3 outputs feed the display driver and the multiplier operand registers.

---
 rtl/keypad_scan_entry.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/keypad_scan_entry.sv
// 4x4 matrix keypad scanner: walks the columns, debounces one key at a time and
// shifts accepted hex codes into a four-digit entry buffer for the display.
module keypad_scan_entry #(
   parameter int CLK_DIV        = 50000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic [3:0] ROW,
   output logic [3:0] COL,
   output logic [3:0] KEY,
   output logic       KeyValid,
   output logic       KeyHeld,
   output logic [3:0] HEX0,
   output logic [3:0] HEX1,
   output logic [3:0] HEX2,
   output logic [3:0] HEX3,
   output logic [1:0] dbg_state
);

   localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int CW = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS + 1) : 1;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2
   } state_t;

   state_t        state, state_nxt;
   logic [3:0]    row_s1, row_s2;
   logic [PW-1:0] pre;
   logic          tick;
   logic [1:0]    col, col_nxt;
   logic [1:0]    lat_row, lat_row_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          accept;
   logic          any_low;
   logic [1:0]    low_row;
   logic          row_up;
   logic [3:0]    code;

   function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
      case ({r, c})
         4'h0: key_code = 4'h1;  4'h1: key_code = 4'h2;  4'h2: key_code = 4'h3;  4'h3: key_code = 4'hA;
         4'h4: key_code = 4'h4;  4'h5: key_code = 4'h5;  4'h6: key_code = 4'h6;  4'h7: key_code = 4'hB;
         4'h8: key_code = 4'h7;  4'h9: key_code = 4'h8;  4'hA: key_code = 4'h9;  4'hB: key_code = 4'hC;
         4'hC: key_code = 4'hE;  4'hD: key_code = 4'h0;  4'hE: key_code = 4'hF;  default: key_code = 4'hD;
      endcase
   endfunction

   assign tick    = (pre == PW'(CLK_DIV - 1));
   assign any_low = ~&row_s2;
   assign row_up  = row_s2[lat_row];
   assign code    = key_code(lat_row, col);

   // Descending loop so the lowest-index low row is the last assignment and wins.
   always_comb begin
      low_row = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (!row_s2[i]) low_row = 2'(i);
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         row_s1  <= 4'b1111;
         row_s2  <= 4'b1111;
         pre     <= '0;
         state   <= SCAN;
         col     <= 2'd0;
         lat_row <= 2'd0;
         cnt     <= '0;
      end else begin
         row_s1  <= ROW;
         row_s2  <= row_s1;
         pre     <= tick ? '0 : pre + 1'b1;
         state   <= state_nxt;
         col     <= col_nxt;
         lat_row <= lat_row_nxt;
         cnt     <= cnt_nxt;
      end
   end

   // The column stays frozen in DEBOUNCE and HELD, so col doubles as the latched column.
   always_comb begin
      state_nxt   = state;
      col_nxt     = col;
      lat_row_nxt = lat_row;
      cnt_nxt     = cnt;
      accept      = 1'b0;
      if (tick) begin
         case (state)
            SCAN: begin
               if (any_low) begin
                  lat_row_nxt = low_row;
                  cnt_nxt     = '0;
                  state_nxt   = DEBOUNCE;
               end else begin
                  col_nxt = col + 2'd1;
               end
            end
            DEBOUNCE: begin
               if (row_up) begin
                  cnt_nxt   = '0;
                  state_nxt = SCAN;
                  col_nxt   = col + 2'd1;
               end else if (cnt == CW'(DEBOUNCE_SCANS - 1)) begin
                  accept    = 1'b1;
                  cnt_nxt   = '0;
                  state_nxt = HELD;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
            HELD: begin
               if (!row_up) begin
                  cnt_nxt = '0;
               end else if (cnt == CW'(DEBOUNCE_SCANS - 1)) begin
                  cnt_nxt   = '0;
                  state_nxt = SCAN;
                  col_nxt   = col + 2'd1;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
            default: state_nxt = SCAN;
         endcase
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         KEY      <= 4'h0;
         KeyValid <= 1'b0;
         HEX0     <= 4'h0;
         HEX1     <= 4'h0;
         HEX2     <= 4'h0;
         HEX3     <= 4'h0;
      end else begin
         KeyValid <= accept;
         if (accept) begin
            KEY  <= code;
            HEX3 <= HEX2;
            HEX2 <= HEX1;
            HEX1 <= HEX0;
            HEX0 <= code;
         end
      end
   end

   assign COL       = ~(4'b0001 << col);
   assign KeyHeld   = (state == HELD);
   assign dbg_state = state;

endmodule
